// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Halt-opcode detection is compiled in only when IFETCH_HALT_EN is defined.
package ifetch_pkg;

    localparam int ADDR_W  = 6;
    localparam int INSTR_W = 16;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);
    localparam logic [3:0] HALT_OPC = 4'b1110;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instrn;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: 4] == HALT_OPC;
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-unit bus: instruction memory side, decode handshake and branch redirect.
// master = fetch unit, slave = memory/decode/branch environment.
interface ifetch_if;
    import ifetch_pkg::*;

    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] in_instrn;
    logic [INSTR_W-1:0] out_instrn;
    logic [ADDR_W-1:0]  out_instrn_pc;
    logic               out_valid;
    logic               in_stall;
    logic               in_branch_taken;
    logic [ADDR_W-1:0]  in_branch_target;

    modport master (
        output out_pc, out_instrn, out_instrn_pc, out_valid,
        input  in_instrn, in_stall, in_branch_taken, in_branch_target
    );

    modport slave (
        input  out_pc, out_instrn, out_instrn_pc, out_valid,
        output in_instrn, in_stall, in_branch_taken, in_branch_target
    );

endinterface

// File: rtl/ifetch_fifo.sv
// Synchronous fetch buffer of fetch_entry_t; flush outranks push and pop.
// When empty, head keeps showing the last entry that was at the head.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wr_data,
    output fetch_entry_t     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    fetch_entry_t     last_head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? last_head : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_head <= '0;
        end else begin
            last_head <= head;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= wr_data;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, single in-flight memory read, credit-based issue, branch redirect.
// Define IFETCH_HALT_EN to stop fetching after a halt opcode is returned.
//
// state | meaning
// RUN   | issuing fetches whenever buffer credit allows
// HALT  | halt word seen; no issue, buffer drains, left only by redirect or reset
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic     clk,
    input  logic     in_rst,
    ifetch_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              inflight;
    logic              issue;
    logic              push;
    logic              pop;
    logic              flush;
    logic              halt_hit;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    credit;
    fetch_entry_t      head;
    fetch_entry_t      wr_entry;

    assign flush    = bus.in_branch_taken;
    assign push     = inflight && !flush;
    assign pop      = !empty && !bus.in_stall;
    assign credit   = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    assign wr_entry = '{instrn: bus.in_instrn, pc: req_pc};

`ifdef IFETCH_HALT_EN
    assign halt_hit = push && is_halt(bus.in_instrn);
`else
    assign halt_hit = 1'b0;
`endif

    assign bus.out_pc        = pc;
    assign bus.out_valid     = !empty;
    assign bus.out_instrn    = head.instrn;
    assign bus.out_instrn_pc = head.pc;

    ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (in_rst),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (wr_entry),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        if (flush) begin
            state_nxt = RUN;
        end else begin
            issue = (state == RUN) && (credit < (CNT_W+1)'(FIFO_DEPTH));
            if (halt_hit) begin
                state_nxt = HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_rst) begin
            state    <= RUN;
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                pc       <= bus.in_branch_target & ~ADDR_W'(1);
                inflight <= 1'b0;
            end else begin
                // the fetch issued alongside a halt word is never accepted
                inflight <= issue && !halt_hit;
                if (issue) begin
                    req_pc <= pc;
                    pc     <= pc + PC_STEP;
                end
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (in_rst)
        !(push && full && !pop));

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: 1-cycle memory model, delivered-stream model, directed checks.
// Build with IFETCH_HALT_EN defined to exercise the halt variant.
module tb_instr_fetch;
    import ifetch_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [INSTR_W-1:0] mem [64];
    logic [ADDR_W-1:0]  exp_pc;
    logic               halted;
    logic               expect_empty;

    ifetch_if bus ();

    instr_fetch #(.FIFO_DEPTH(2), .RESET_PC(6'd0)) dut (
        .clk    (clk),
        .in_rst (rst),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) bus.in_instrn <= mem[bus.out_pc];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Delivered-stream model: decode must see consecutive PCs from the last redirect/reset, each
    // with the memory word at that PC, nothing right after a flush, nothing after a halt word.
    initial begin
        exp_pc       = '0;
        halted       = 1'b0;
        expect_empty = 1'b0;
        forever begin
            @(negedge clk);
            if (expect_empty) check("empty_after_flush", 32'(bus.out_valid), 0);
            expect_empty = 1'b0;
            if (halted) begin
                check("valid_after_halt", 32'(bus.out_valid), 0);
            end else if (bus.out_valid === 1'b1) begin
                check("model_pc", 32'(bus.out_instrn_pc), 32'(exp_pc));
                check("model_instrn", 32'(bus.out_instrn), 32'(mem[exp_pc]));
            end
            if (rst) begin
                exp_pc       = 6'd0;
                halted       = 1'b0;
                expect_empty = 1'b1;
            end else if (bus.in_branch_taken) begin
                exp_pc       = bus.in_branch_target & 6'h3E;
                halted       = 1'b0;
                expect_empty = 1'b1;
            end else if (bus.out_valid === 1'b1 && !bus.in_stall && !halted) begin
`ifdef IFETCH_HALT_EN
                if (mem[exp_pc][15:12] == 4'hE) halted = 1'b1;
`endif
                exp_pc = exp_pc + 6'd2;
            end
        end
    end

    initial begin
        int exp_seq [4];
        n_checks = 0;
        n_fail   = 0;
        for (int a = 0; a < 64; a++) mem[a] = 16'h0200 + 16'(a);
        mem[0]  = 16'h0120;
        mem[34] = 16'h0110;
        mem[50] = 16'hEFFF;

        rst                  = 1'b1;
        bus.in_stall         = 1'b0;
        bus.in_branch_taken  = 1'b0;
        bus.in_branch_target = '0;
        step;
        step;
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_instrn", 32'(bus.out_instrn), 0);
        check("rst_instrn_pc", 32'(bus.out_instrn_pc), 0);
        check("rst_out_pc", 32'(bus.out_pc), 0);

        // 1: release reset, free-running fetch
        rst = 1'b0;
        check("t1_pc0", 32'(bus.out_pc), 0);
        step;
        check("t1_pc1", 32'(bus.out_pc), 2);
        check("t1_no_valid_yet", 32'(bus.out_valid), 0);
        step;
        check("t1_pc2", 32'(bus.out_pc), 4);
        check("t1_first_valid", 32'(bus.out_valid), 1);
        check("t1_first_instrn", 32'(bus.out_instrn), 'h0120);
        check("t1_first_pc", 32'(bus.out_instrn_pc), 0);

        // 2: stall six cycles from first valid
        bus.in_stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step;
            check("t2_hold_instrn", 32'(bus.out_instrn), 'h0120);
            check("t2_hold_pc", 32'(bus.out_instrn_pc), 0);
            check("t2_pc_frozen", 32'(bus.out_pc), 4);
        end
        bus.in_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            check("t2_resume", 32'(bus.out_instrn_pc), 32'(2 + 2 * i));
        end

        // 3: redirect to 35 while full and stalled
        bus.in_stall = 1'b1;
        step;
        step;
        step;
        check("t3_full_head", 32'(bus.out_instrn_pc), 6);
        check("t3_full_out_pc", 32'(bus.out_pc), 10);
        bus.in_branch_taken  = 1'b1;
        bus.in_branch_target = 6'd35;
        bus.in_stall         = 1'b0;
        step;
        bus.in_branch_taken = 1'b0;
        check("t3_flush_valid", 32'(bus.out_valid), 0);
        check("t3_target_pc", 32'(bus.out_pc), 34);
        step;
        check("t3_latency", 32'(bus.out_valid), 0);
        step;
        check("t3_target_valid", 32'(bus.out_valid), 1);
        check("t3_target_instrn", 32'(bus.out_instrn), 'h0110);
        check("t3_target_ipc", 32'(bus.out_instrn_pc), 34);

        // 4: redirect to 60, PC wraps
        bus.in_branch_taken  = 1'b1;
        bus.in_branch_target = 6'd60;
        step;
        bus.in_branch_taken = 1'b0;
        check("t4_out_pc", 32'(bus.out_pc), 60);
        step;
        exp_seq = '{60, 62, 0, 2};
        for (int i = 0; i < 4; i++) begin
            step;
            check("t4_wrap_seq", 32'(bus.out_instrn_pc), 32'(exp_seq[i]));
        end

        // 5: run into the halt word at 50
        bus.in_branch_taken  = 1'b1;
        bus.in_branch_target = 6'd44;
        step;
        bus.in_branch_taken = 1'b0;
        step;
        for (int i = 0; i < 3; i++) begin
            step;
            check("t5_lead_in", 32'(bus.out_instrn_pc), 32'(44 + 2 * i));
        end
        step;
        check("t5_halt_ipc", 32'(bus.out_instrn_pc), 50);
        check("t5_halt_instrn", 32'(bus.out_instrn), 'hEFFF);
        check("t5_halt_out_pc", 32'(bus.out_pc), 54);
        step;
`ifdef IFETCH_HALT_EN
        check("t5_halted_valid", 32'(bus.out_valid), 0);
        check("t5_halted_pc", 32'(bus.out_pc), 54);
        step;
        step;
        check("t5_still_halted", 32'(bus.out_valid), 0);
        check("t5_pc_held", 32'(bus.out_pc), 54);
`else
        check("t5_next_valid", 32'(bus.out_valid), 1);
        check("t5_next_ipc", 32'(bus.out_instrn_pc), 52);
        check("t5_next_out_pc", 32'(bus.out_pc), 56);
`endif
        bus.in_branch_taken  = 1'b1;
        bus.in_branch_target = 6'd0;
        step;
        bus.in_branch_taken = 1'b0;
        step;
        step;
        check("t5_resume_valid", 32'(bus.out_valid), 1);
        check("t5_resume_instrn", 32'(bus.out_instrn), 'h0120);
        check("t5_resume_ipc", 32'(bus.out_instrn_pc), 0);

        // 6: mid-stream reset with a full buffer
        bus.in_stall = 1'b1;
        step;
        step;
        step;
        rst          = 1'b1;
        bus.in_stall = 1'b0;
        step;
        rst = 1'b0;
        check("t6_valid", 32'(bus.out_valid), 0);
        check("t6_out_pc", 32'(bus.out_pc), 0);
        check("t6_instrn", 32'(bus.out_instrn), 0);
        check("t6_instrn_pc", 32'(bus.out_instrn_pc), 0);
        step;
        check("t6_pc1", 32'(bus.out_pc), 2);
        check("t6_no_valid_yet", 32'(bus.out_valid), 0);
        step;
        check("t6_pc2", 32'(bus.out_pc), 4);
        check("t6_first_instrn", 32'(bus.out_instrn), 'h0120);
        check("t6_first_ipc", 32'(bus.out_instrn_pc), 0);

        // reset and redirect together: reset wins
        rst                  = 1'b1;
        bus.in_branch_taken  = 1'b1;
        bus.in_branch_target = 6'd20;
        step;
        rst                 = 1'b0;
        bus.in_branch_taken = 1'b0;
        check("t6_rr_out_pc", 32'(bus.out_pc), 0);
        check("t6_rr_valid", 32'(bus.out_valid), 0);
        step;
        step;
        check("t6_rr_instrn", 32'(bus.out_instrn), 'h0120);
        check("t6_rr_ipc", 32'(bus.out_instrn_pc), 0);
        step;
        step;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
